// File: rtl/alu_op_sequencer_if.sv
// Command/handshake bundle between the op sequencer, its host and the ALU datapath.
interface alu_op_sequencer_if #(
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
);
  logic          Load;
  logic [AW-1:0] LoadAddr;
  logic [3:0]    LoadData;
  logic [1:0]    LoadFunc;
  logic          Start;
  logic [AW:0]   Length;
  logic [7:0]    ALUout;
  logic [3:0]    Data;
  logic [1:0]    Function;
  logic          AluEn;
  logic          AluClr;
  logic [7:0]    Result;
  logic          Busy;
  logic          Done;
  logic          Error;

  modport master (
    output Load, LoadAddr, LoadData, LoadFunc, Start, Length, ALUout,
    input  Data, Function, AluEn, AluClr, Result, Busy, Done, Error
  );

  modport slave (
    input  Load, LoadAddr, LoadData, LoadFunc, Start, Length, ALUout,
    output Data, Function, AluEn, AluClr, Result, Busy, Done, Error
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// Plays a stored program of {func,data} ops into the 4/8-bit ALU, then hands back
// the final accumulator value with a Done pulse.
module alu_op_sequencer #(
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input logic               Clock,
  input logic               Reset_b,
  alu_op_sequencer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, CLEAR, ISSUE, CAPTURE} state_t;

  state_t        r_state, w_next;
  logic [5:0]    r_prog [DEPTH];
  logic [AW-1:0] r_idx;
  logic [AW:0]   r_len;
  logic [7:0]    r_result;
  logic          r_error;
  logic          w_len_ok;
  logic          w_accept;
  logic          w_last;
  logic [5:0]    w_slot;

  assign w_len_ok = (bus.Length != '0) && (bus.Length <= (AW+1)'(DEPTH));
  assign w_accept = (r_state == IDLE) && bus.Start && w_len_ok;
  assign w_last   = ({1'b0, r_idx} == (r_len - 1'b1));
  assign w_slot   = r_prog[r_idx];

  always_ff @(posedge Clock or posedge Reset_b) begin
    if (Reset_b) r_state <= IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = CLEAR;
      CLEAR:   w_next = ISSUE;
      ISSUE:   if (w_last) w_next = CAPTURE;
      CAPTURE: w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Load and Start in the same cycle both land here; the slot is read later in ISSUE.
  always_ff @(posedge Clock or posedge Reset_b) begin
    if (Reset_b) begin
      for (int i = 0; i < DEPTH; i++) r_prog[i] <= '0;
    end else if (r_state == IDLE && bus.Load) begin
      r_prog[bus.LoadAddr] <= {bus.LoadFunc, bus.LoadData};
    end
  end

  always_ff @(posedge Clock or posedge Reset_b) begin
    if (Reset_b) begin
      r_idx    <= '0;
      r_len    <= '0;
      r_result <= '0;
      r_error  <= 1'b0;
    end else begin
      r_error <= (r_state == IDLE) && bus.Start && !w_len_ok;
      if (w_accept) begin
        r_len <= bus.Length;
        r_idx <= '0;
      end else if (r_state == ISSUE) begin
        r_idx <= r_idx + 1'b1;
      end
      if (r_state == CAPTURE) r_result <= bus.ALUout;
    end
  end

  // Idle function is "hold", except while reset is asserted where every output reads 0.
  assign bus.Data     = (r_state == ISSUE) ? w_slot[3:0] : 4'd0;
  assign bus.Function = (r_state == ISSUE) ? w_slot[5:4] : (Reset_b ? 2'b00 : 2'b11);
  assign bus.AluEn    = (r_state == ISSUE);
  assign bus.AluClr   = (r_state == CLEAR);
  assign bus.Busy     = (r_state == CLEAR) || (r_state == ISSUE);
  assign bus.Done     = (r_state == CAPTURE);
  assign bus.Result   = (r_state == CAPTURE) ? bus.ALUout : r_result;
  assign bus.Error    = r_error;

endmodule

// File: doc/alu_op_sequencer.md
# alu_op_sequencer

Issues a stored program of up to DEPTH operations to the 4-bit-input / 8-bit-accumulator ALU datapath (Data, Function, ALUout with its 8-bit result register). It drives the ALU's operand and function inputs and register enable, then returns the final accumulator value on a handshake. It sits upstream of the ALU as its command source, and doubles as the ALU's test driver on the board.

## Interface
- DEPTH, 8, number of program slots; power of two, 2..16
- AW, log2(DEPTH), slot address width
- Clock  in  1  single system clock, all state on rising edge
- Reset_b  in  1  asynchronous, active-high reset; clears all state and outputs
- Load  in  1  write one program slot this cycle (honoured only in IDLE)
- LoadAddr  in  AW  slot index to write
- LoadData  in  4  operand A for that slot
- LoadFunc  in  2  ALU function code for that slot
- Start  in  1  single-cycle request to run slots 0..Length-1
- Length  in  AW+1  number of operations to issue, valid 1..DEPTH, sampled with Start
- ALUout  in  8  current ALU accumulator register value
- Data  out  4  operand A to ALU
- Function  out  2  function code to ALU
- AluEn  out  1  ALU register load enable
- AluClr  out  1  synchronous clear request to ALU register
- Result  out  8  captured final accumulator value
- Busy  out  1  high from the cycle after an accepted Start until Done
- Done  out  1  one-cycle pulse, Result valid from this cycle
- Error  out  1  one-cycle pulse on rejected Start

## Operation
- ALU contract (B = ALUout[3:0]): 00 A+B, 01 A*B, 10 B<<A, 11 hold; register loads only when AluEn=1, clears when AluClr=1.
- Program store: DEPTH x 6 bits {func,data}; written in IDLE when Load=1; Load outside IDLE ignored; contents survive runs; reset clears all slots to 0.
- States: IDLE, CLEAR, ISSUE, CAPTURE.
- IDLE: Start with 1<=Length<=DEPTH -> latch Length, idx=0, go CLEAR. Start with Length=0 or >DEPTH -> Error pulse, stay IDLE. Start and Load same cycle: Load performed first, Start then accepted (new slot content used).
- CLEAR: AluClr=1 one cycle -> ISSUE.
- ISSUE: Data/Function = slot[idx], AluEn=1; idx++ each cycle; after idx = Length-1 issued -> CAPTURE.
- CAPTURE: Result <= ALUout, Done=1 -> IDLE.
- Start while Busy: ignored, no Error.
- Result holds until next Done or reset.
- Reset in any state: immediate return to IDLE; slots, Result, idx cleared; no Done.

## Timing
- Reset values: Data=0, Function=0, AluEn=0, AluClr=0, Result=0, Busy=0, Done=0, Error=0.
- Outputs Data, Function, AluEn, AluClr registered-free from state (Moore); valid whole cycle.
- Start sampled at edge T (IDLE): CLEAR during T+1, ISSUE T+2..T+1+Length, CAPTURE/Done at T+2+Length.
- Total Start-to-Done latency: Length+2 cycles; next Start accepted the cycle after Done.
- ALU result of op k visible on ALUout cycle after its ISSUE cycle, so op k+1 uses it as B back-to-back.
- Data/Function outside ISSUE: 0/2'b11 (hold), AluEn=0.
- Error asserted the cycle after offending Start edge, one cycle only.
- Busy high CLEAR..CAPTURE inclusive? No: Busy high in CLEAR and ISSUE, low in CAPTURE and IDLE; Done marks completion.

## Test plan
- Reset mid-run: Load slots, Start Length=4, assert Reset_b in 2nd ISSUE cycle -> all outputs 0 same cycle, IDLE after release, no Done, slots read back 0 on a subsequent run (Result=0).
- Add chain: slots {00,3},{00,5},{00,2}, Start Length=3 -> AluClr at T+1, AluEn T+2..T+4, Done at T+5, Result=8'h0A.
- Mixed ops: slots {00,3},{01,4},{10,1}, Length=3 -> 3, 12, 12[3:0]<<1 = 8'h18; Result=8'h18, Done at T+5.
- Length bounds: Start Length=0 -> Error pulse, Busy stays 0; Length=DEPTH+1 -> Error; Length=DEPTH all {00,1} -> Result=DEPTH, Done at T+DEPTH+2.
- Collisions: Start while Busy ignored (single Done); Load while Busy ignored (slot unchanged next run); Load slot0={00,7} with Start Length=1 same cycle -> Result=8'h07.
- Back-to-back: Start again the cycle after Done, Length=1 slot {11,x} -> Result=0 (cleared then hold), Done at T+3.
